// File: rtl/stack_pkg.sv
// Shared types and helpers for the parametrised LIFO stack.
package stack_pkg;

  // Encoded directly as {push, pop}.
  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } op_t;

  // The count register must hold 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stack_ram.sv
// Storage array: one synchronous write port, one asynchronous read port.
module stack_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_stack.sv
// LIFO stack with replace-top, registered pop data, sticky error flags and flush.
module param_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 128,
  parameter int CW    = count_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic             clear_err,
  output logic [WIDTH-1:0] d_out,
  output logic             d_valid,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [CW-1:0]    count_q;
  logic [AW-1:0]    top_addr;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] rdata;
  logic             we;
  op_t              op;

  assign op       = op_t'({push, pop});
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign top_addr = AW'(count_q - CW'(1));
  // Stale memory is never exposed: reads are gated by count.
  assign top      = empty ? '0 : rdata;

  // Write port decode; reset and flush discard the cycle's requests.
  always_comb begin
    we    = 1'b0;
    waddr = AW'(count_q);
    if (!reset && !flush) begin
      unique case (op)
        OP_PUSH: we = !full;
        OP_REPLACE: begin
          we    = 1'b1;
          waddr = empty ? AW'(count_q) : top_addr;
        end
        default: we = 1'b0;
      endcase
    end
  end

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clock (clock),
    .we    (we),
    .waddr (waddr),
    .wdata (d_in),
    .raddr (top_addr),
    .rdata (rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q   <= '0;
      d_out     <= '0;
      d_valid   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      d_valid <= 1'b0;
      // A new error in the same cycle overrides clear_err below.
      if (clear_err) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (flush) begin
        count_q <= '0;
      end else begin
        unique case (op)
          OP_PUSH: begin
            if (full) overflow <= 1'b1;
            else      count_q  <= count_q + CW'(1);
          end
          OP_POP: begin
            if (empty) begin
              underflow <= 1'b1;
            end else begin
              d_out   <= rdata;
              d_valid <= 1'b1;
              count_q <= count_q - CW'(1);
            end
          end
          OP_REPLACE: begin
            if (empty) begin
              underflow <= 1'b1;
              count_q   <= CW'(1);
            end else begin
              d_out   <= rdata;
              d_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack with WIDTH=16, DEPTH=4.
module tb_param_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] d_in;
  logic             push, pop, flush, clear_err;
  logic [WIDTH-1:0] d_out, top;
  logic             d_valid, empty, full, overflow, underflow;
  logic [CW-1:0]    count;

  int compared   = 0;
  int mismatched = 0;

  param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .d_in      (d_in),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .clear_err (clear_err),
    .d_out     (d_out),
    .d_valid   (d_valid),
    .top       (top),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests, then sample 1 time unit after the edge.
  task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d,
                      input logic f = 1'b0, input logic c = 1'b0, input logic r = 1'b0);
    push = p; pop = q; d_in = d; flush = f; clear_err = c; reset = r;
    @(posedge clock);
    #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0; clear_err = 1'b0; reset = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_top"}, 32'(top), 32'h0);
    chk({tag, "_dout"}, 32'(d_out), 32'h0);
    chk({tag, "_dvalid"}, 32'(d_valid), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_unf"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    push = 0; pop = 0; flush = 0; clear_err = 0; d_in = '0; reset = 1;
    // Reset
    step(0, 0, 16'h0, 0, 0, 1);
    step(0, 0, 16'h0, 0, 0, 1);
    chk_reset_state("rst");

    // Fill to full
    step(1, 0, 16'h1111); chk("push1_count", 32'(count), 32'd1); chk("push1_top", 32'(top), 32'h1111);
    step(1, 0, 16'h2222); chk("push2_top", 32'(top), 32'h2222);
    step(1, 0, 16'h3333); chk("push3_full", 32'(full), 32'd0);
    step(1, 0, 16'h4444);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_top", 32'(top), 32'h4444);
    chk("fill_ovf", 32'(overflow), 32'd0);

    // Overflow
    step(1, 0, 16'h5555);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_top", 32'(top), 32'h4444);

    // Back-to-back pops
    step(0, 1, 16'h0); chk("pop1_dout", 32'(d_out), 32'h4444); chk("pop1_dv", 32'(d_valid), 32'd1);
    chk("pop1_top", 32'(top), 32'h3333);
    step(0, 1, 16'h0); chk("pop2_dout", 32'(d_out), 32'h3333); chk("pop2_dv", 32'(d_valid), 32'd1);
    step(0, 1, 16'h0); chk("pop3_dout", 32'(d_out), 32'h2222); chk("pop3_dv", 32'(d_valid), 32'd1);
    step(0, 1, 16'h0); chk("pop4_dout", 32'(d_out), 32'h1111); chk("pop4_dv", 32'(d_valid), 32'd1);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_top", 32'(top), 32'h0);
    chk("drain_count", 32'(count), 32'd0);

    // Underflow
    step(0, 1, 16'h0);
    chk("unf_flag", 32'(underflow), 32'd1);
    chk("unf_dv", 32'(d_valid), 32'd0);
    chk("unf_dout", 32'(d_out), 32'h1111);
    chk("unf_ovf_sticky", 32'(overflow), 32'd1);

    // clear_err alone, then clear_err with a new underflow
    step(0, 0, 16'h0, 0, 1);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_unf", 32'(underflow), 32'd0);
    step(0, 1, 16'h0, 0, 1);
    chk("clr_new_unf", 32'(underflow), 32'd1);
    chk("clr_new_ovf", 32'(overflow), 32'd0);
    step(0, 0, 16'h0, 0, 1);

    // Replace on a full stack
    step(1, 0, 16'h1111); step(1, 0, 16'h2222); step(1, 0, 16'h3333); step(1, 0, 16'h4444);
    step(1, 1, 16'hAAAA);
    chk("rep_dout", 32'(d_out), 32'h4444);
    chk("rep_dv", 32'(d_valid), 32'd1);
    chk("rep_top", 32'(top), 32'hAAAA);
    chk("rep_count", 32'(count), 32'd4);
    chk("rep_ovf", 32'(overflow), 32'd0);
    step(0, 0, 16'h0);
    chk("idle_dv", 32'(d_valid), 32'd0);
    chk("idle_dout_hold", 32'(d_out), 32'h4444);

    // Flush keeps d_out
    step(0, 0, 16'h0, 1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_top", 32'(top), 32'h0);
    chk("flush_dout", 32'(d_out), 32'h4444);

    // Push & pop on empty
    step(1, 1, 16'hBEEF);
    chk("pp_empty_count", 32'(count), 32'd1);
    chk("pp_empty_top", 32'(top), 32'hBEEF);
    chk("pp_empty_unf", 32'(underflow), 32'd1);
    chk("pp_empty_dv", 32'(d_valid), 32'd0);
    chk("pp_empty_dout", 32'(d_out), 32'h4444);

    // Flush beats push at count=3; flags stay sticky through flush
    step(1, 0, 16'h3C3C); step(1, 0, 16'h4D4D);
    chk("pre_flush_count", 32'(count), 32'd3);
    step(1, 0, 16'h7777, 1);
    chk("fp_count", 32'(count), 32'd0);
    chk("fp_top", 32'(top), 32'h0);
    chk("fp_unf_sticky", 32'(underflow), 32'd1);
    step(1, 0, 16'h1234);
    chk("post_flush_top", 32'(top), 32'h1234);
    chk("post_flush_count", 32'(count), 32'd1);

    // Reset mid pop-burst
    step(1, 0, 16'h5678); step(1, 0, 16'h9ABC);
    step(0, 1, 16'h0);
    chk("burst_dout", 32'(d_out), 32'h9ABC);
    step(0, 1, 16'h0, 0, 0, 1);
    chk_reset_state("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
